// File: rtl/clock_gating_ctrl.sv
// Per-unit clock-gating controller: gates each unit's clock after an idle window and
// re-enables it on demand, holding off the grant until the clock has settled.
module clock_gating_ctrl #(
   parameter int unsigned NUM_UNITS   = 4,
   parameter int unsigned IDLE_CYCLES = 16,
   parameter int unsigned WAKE_CYCLES = 2
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               ctrl_en_i,
   input  logic [NUM_UNITS-1:0]               force_on_i,
   input  logic [NUM_UNITS-1:0]               busy_i,
   input  logic [NUM_UNITS-1:0]               req_i,
   output logic [NUM_UNITS-1:0]               gnt_o,
   output logic [NUM_UNITS-1:0]               cg_en_o,
   output logic [NUM_UNITS-1:0]               gated_o,
   output logic [$clog2(NUM_UNITS+1)-1:0]     gated_cnt_o
);

   localparam int unsigned MAX_CYC = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
   localparam int unsigned POP_W   = $clog2(NUM_UNITS + 1);

   localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

   typedef enum logic [1:0] {
      StOn,
      StIdle,
      StOff,
      StWake
   } state_e;

   state_e           state_q [NUM_UNITS];
   logic [CNT_W-1:0] cnt_q   [NUM_UNITS];

   logic [NUM_UNITS-1:0] wake_cond;

   // A disabled controller counts as a wake source for every unit.
   assign wake_cond = req_i | busy_i | force_on_i | {NUM_UNITS{~ctrl_en_i}};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            state_q[i] <= StOn;
            cnt_q[i]   <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            case (state_q[i])
               StOn: begin
                  if (!wake_cond[i]) begin
                     state_q[i] <= StIdle;
                     cnt_q[i]   <= IDLE_LOAD;
                  end
               end
               StIdle: begin
                  // Wake wins over expiry on the same edge.
                  if (wake_cond[i]) begin
                     state_q[i] <= StOn;
                  end else if (cnt_q[i] == '0) begin
                     state_q[i] <= StOff;
                  end else begin
                     cnt_q[i] <= cnt_q[i] - 1'b1;
                  end
               end
               StOff: begin
                  if (wake_cond[i]) begin
                     state_q[i] <= StWake;
                     cnt_q[i]   <= WAKE_LOAD;
                  end
               end
               StWake: begin
                  // Settle window always completes, so the grant is never early.
                  if (cnt_q[i] == '0) begin
                     state_q[i] <= StOn;
                  end else begin
                     cnt_q[i] <= cnt_q[i] - 1'b1;
                  end
               end
               default: begin
                  state_q[i] <= StOn;
                  cnt_q[i]   <= '0;
               end
            endcase
         end
      end
   end

   always_comb begin
      logic [POP_W-1:0] pop;
      pop     = '0;
      cg_en_o = '0;
      gnt_o   = '0;
      gated_o = '0;
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
         cg_en_o[i] = (state_q[i] != StOff);
         gnt_o[i]   = (state_q[i] == StOn) || (state_q[i] == StIdle);
         gated_o[i] = (state_q[i] == StOff);
         pop        = pop + POP_W'(gated_o[i]);
      end
      gated_cnt_o = pop;
   end

endmodule

// File: tb/tb_clock_gating_ctrl.sv
// Self-checking bench for clock_gating_ctrl: idle-sample/settle-count model compared every
// cycle, plus literal expectations at the key points of each scenario.
module tb_clock_gating_ctrl;

   localparam int unsigned NU = 4;
   localparam int unsigned IC = 16;
   localparam int unsigned WC = 2;

   logic          clk_i;
   logic          rst_ni;
   logic          ctrl_en_i;
   logic [NU-1:0] force_on_i;
   logic [NU-1:0] busy_i;
   logic [NU-1:0] req_i;
   logic [NU-1:0] gnt_o;
   logic [NU-1:0] cg_en_o;
   logic [NU-1:0] gated_o;
   logic [2:0]    gated_cnt_o;

   int checks;
   int errors;

   // Model: per unit, whether it is gated, settle edges still to go, and the run of
   // consecutive idle samples seen while clocked and granted.
   bit m_off  [NU];
   int m_wake [NU];
   int m_run  [NU];

   clock_gating_ctrl #(
      .NUM_UNITS  (NU),
      .IDLE_CYCLES(IC),
      .WAKE_CYCLES(WC)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .ctrl_en_i  (ctrl_en_i),
      .force_on_i (force_on_i),
      .busy_i     (busy_i),
      .req_i      (req_i),
      .gnt_o      (gnt_o),
      .cg_en_o    (cg_en_o),
      .gated_o    (gated_o),
      .gated_cnt_o(gated_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < NU; i++) begin
         bit w;
         w = req_i[i] | busy_i[i] | force_on_i[i] | ~ctrl_en_i;
         if (!rst_ni) begin
            m_off[i]  = 1'b0;
            m_wake[i] = 0;
            m_run[i]  = 0;
         end else if (m_off[i]) begin
            if (w) begin
               m_off[i]  = 1'b0;
               m_wake[i] = WC;
            end
         end else if (m_wake[i] > 0) begin
            m_wake[i] = m_wake[i] - 1;
         end else if (w) begin
            m_run[i] = 0;
         end else begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == IC + 1) begin
               m_off[i] = 1'b1;
               m_run[i] = 0;
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < NU; i++) begin
         m_off[i]  = 1'b0;
         m_wake[i] = 0;
         m_run[i]  = 0;
      end
      forever begin
         @(posedge clk_i);
         model_step();
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk_i);
         if (rst_ni) begin
            logic [NU-1:0] e_cg, e_gnt, e_gated;
            int e_cnt;
            e_cnt = 0;
            for (int i = 0; i < NU; i++) begin
               e_cg[i]    = ~m_off[i];
               e_gnt[i]   = ~m_off[i] && (m_wake[i] == 0);
               e_gated[i] = m_off[i];
               e_cnt      = e_cnt + int'(m_off[i]);
            end
            chk("model_cg_en", 32'(cg_en_o), 32'(e_cg));
            chk("model_gnt", 32'(gnt_o), 32'(e_gnt));
            chk("model_gated", 32'(gated_o), 32'(e_gated));
            chk("model_gated_cnt", 32'(gated_cnt_o), 32'(e_cnt));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk_i);
         #1;
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst_ni     = 1'b1;
      ctrl_en_i  = 1'b1;
      force_on_i = '0;
      busy_i     = '0;
      req_i      = '0;
      #1 rst_ni = 1'b0;
      #1;
      chk("rst_cg_en", 32'(cg_en_o), 32'hF);
      chk("rst_gnt", 32'(gnt_o), 32'hF);
      chk("rst_gated", 32'(gated_o), 32'h0);
      chk("rst_gated_cnt", 32'(gated_cnt_o), 32'h0);
      tick(2);
      rst_ni = 1'b1;

      // Full idle window: still clocked after edge k+15, gated after edge k+16.
      tick(16);
      chk("idle_edge15_cg_en", 32'(cg_en_o), 32'hF);
      chk("idle_edge15_cnt", 32'(gated_cnt_o), 32'h0);
      tick(1);
      chk("idle_edge16_cg_en", 32'(cg_en_o), 32'h0);
      chk("idle_edge16_gnt", 32'(gnt_o), 32'h0);
      chk("idle_edge16_cnt", 32'(gated_cnt_o), 32'h4);

      // Wake unit 0 by request.
      req_i = 4'b0001;
      tick(1);
      chk("wake_k_cg_en", 32'(cg_en_o), 32'h1);
      chk("wake_k_gnt", 32'(gnt_o), 32'h0);
      chk("wake_k_cnt", 32'(gated_cnt_o), 32'h3);
      tick(1);
      chk("wake_k1_gnt", 32'(gnt_o), 32'h0);
      tick(1);
      chk("wake_k2_gnt", 32'(gnt_o), 32'h1);
      req_i = '0;

      // Global disable: gated units take the full wake path.
      ctrl_en_i = 1'b0;
      tick(1);
      chk("dis_k_cg_en", 32'(cg_en_o), 32'hF);
      chk("dis_k_gnt", 32'(gnt_o), 32'h1);
      tick(1);
      chk("dis_k1_gnt", 32'(gnt_o), 32'h1);
      tick(1);
      chk("dis_k2_gnt", 32'(gnt_o), 32'hF);
      tick(20);
      chk("dis_hold_cg_en", 32'(cg_en_o), 32'hF);
      chk("dis_hold_cnt", 32'(gated_cnt_o), 32'h0);

      // Only the forced unit stays clocked.
      ctrl_en_i  = 1'b1;
      force_on_i = 4'b1000;
      tick(16);
      chk("force_edge15_cg_en", 32'(cg_en_o), 32'hF);
      tick(1);
      chk("force_edge16_cg_en", 32'(cg_en_o), 32'h8);
      chk("force_edge16_cnt", 32'(gated_cnt_o), 32'h3);

      // Bring everything back, then busy pulse on unit 1 and late request on unit 2.
      force_on_i = 4'b1111;
      tick(3);
      chk("force_all_gnt", 32'(gnt_o), 32'hF);
      force_on_i = '0;
      tick(10);
      busy_i = 4'b0010;
      tick(1);
      busy_i = '0;
      tick(5);
      req_i = 4'b0100;
      tick(1);
      chk("expiry_req_cg_en", 32'(cg_en_o), 32'h6);
      chk("expiry_req_gnt", 32'(gnt_o), 32'h6);
      chk("expiry_req_cnt", 32'(gated_cnt_o), 32'h2);
      tick(10);
      chk("busy_restart_early_cg_en", 32'(cg_en_o), 32'h6);
      tick(1);
      chk("busy_restart_cg_en", 32'(cg_en_o), 32'h4);
      chk("busy_restart_cnt", 32'(gated_cnt_o), 32'h3);

      // Asynchronous reset while unit 0 is mid-settle.
      req_i = 4'b0001;
      tick(1);
      chk("pre_rst_gnt0", 32'(gnt_o[0]), 32'h0);
      #2 rst_ni = 1'b0;
      #1;
      chk("async_rst_cg_en", 32'(cg_en_o), 32'hF);
      chk("async_rst_gnt", 32'(gnt_o), 32'hF);
      chk("async_rst_gated", 32'(gated_o), 32'h0);
      chk("async_rst_cnt", 32'(gated_cnt_o), 32'h0);
      req_i = '0;
      tick(1);
      rst_ni = 1'b1;

      // Mixed traffic under the model only.
      tick(5);
      busy_i = 4'b0101;
      tick(3);
      busy_i = '0;
      tick(20);
      req_i = 4'b1111;
      tick(4);
      req_i = 4'b0000;
      busy_i = 4'b1000;
      tick(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
